rr_arbiter_ctrl: RTL and testbench

Round-robin arbiter with grant hold and a hold-time limit. It shares one downstream resource among NUM_REQ requesters. It extends the existing 2-requester combinational arbiter into a registered, fair scheduler: the grant is held while the owner keeps requesting, and is forcibly rotated after MAX_HOLD cycles when other requesters are waiting. It sits between the requester interfaces and the shared resource mux, and drives the mux select with grant_id.

---
 rtl/rr_arbiter_ctrl_if.sv | 34 +++
 rtl/rr_arbiter_ctrl.sv | 164 ++++++++++++++++
 tb/tb_rr_arbiter_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_ctrl_if.sv
// rtl/rr_arbiter_ctrl_if.sv - request/grant bundle between requesters and rr_arbiter_ctrl
//   request  : per-requester request level (driven by requesters)
//   grant    : registered one-hot grant, zero when idle
//   grant_id : binary index of the owner, meaningful only while busy
//   busy     : any grant bit set
//   rotate   : one-cycle pulse when a hold-limit rotation takes effect
//   master modport = requester side, slave modport = arbiter side
interface rr_arbiter_ctrl_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               rotate;

    modport master (
        output request,
        input  grant,
        input  grant_id,
        input  busy,
        input  rotate
    );

    modport slave (
        input  request,
        output grant,
        output grant_id,
        output busy,
        output rotate
    );
endinterface

// File: rtl/rr_arbiter_ctrl.sv
// rtl/rr_arbiter_ctrl.sv - registered round-robin arbiter with grant hold and hold-time limit
//   clk      : single clock, rising edge
//   reset_n  : asynchronous active-low reset
//   arb      : rr_arbiter_ctrl_if.slave (request in; grant, grant_id, busy, rotate out)
//   Optional macro ARB_HOLD_LIMIT_EN: when defined, an owner that has held the grant for
//   MAX_HOLD cycles while others wait is forcibly rotated out and rotate pulses; when
//   undefined the owner keeps the grant until it drops its request and rotate is 0.
module rr_arbiter_ctrl #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    rr_arbiter_ctrl_if.slave  arb
);
    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || MAX_HOLD < 1) begin : g_bad_params
            $error("rr_arbiter_ctrl: NUM_REQ must be 2..16 and MAX_HOLD >= 1");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t             state;
    logic [NUM_REQ-1:0] grant_q;
    logic [ID_W-1:0]    grant_id_q;
    logic               busy_q;
    logic [ID_W-1:0]    ptr;

`ifdef ARB_HOLD_LIMIT_EN
    localparam int               CNT_W    = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    logic [CNT_W-1:0] hold_cnt;
    logic             rotate_q;
    logic             hold_expired;
    logic             others_pending;

    assign hold_expired   = (hold_cnt == HOLD_MAX);
    // grant_q is the owner's one-hot in OWN, so masking it leaves only waiting requesters
    assign others_pending = |(arb.request & ~grant_q);
`endif

    logic               owner_req;
    logic [ID_W-1:0]    owner_next;
    logic [ID_W-1:0]    scan_base;
    logic [NUM_REQ-1:0] rotated;
    logic [NUM_REQ-1:0] scan_tmp;
    logic               found;
    logic [ID_W-1:0]    offset;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    win;
    logic [NUM_REQ-1:0] win_onehot;

    assign owner_req  = arb.request[grant_id_q];
    assign owner_next = (grant_id_q == LAST_ID) ? '0 : grant_id_q + ID_W'(1);

    // From IDLE the scan starts at the round-robin pointer; from OWN (release or forced
    // rotation) it starts just past the current owner.
    assign scan_base  = (state == IDLE) ? ptr : owner_next;

    // Rotate the request vector so bit 0 is the scan start, then find the lowest set bit.
    assign rotated = NUM_REQ'({arb.request, arb.request} >> scan_base);

    always_comb begin
        scan_tmp = rotated;
        found    = 1'b0;
        offset   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found) begin
                if (scan_tmp[0]) begin
                    found = 1'b1;
                end else begin
                    offset = offset + ID_W'(1);
                end
            end
            scan_tmp = scan_tmp >> 1;
        end
    end

    // Map the offset back to an absolute requester index modulo NUM_REQ, which need not
    // be a power of two.
    assign win_sum    = {1'b0, scan_base} + {1'b0, offset};
    assign win        = (win_sum >= NUM_REQ_W) ? ID_W'(win_sum - NUM_REQ_W) : win_sum[ID_W-1:0];
    assign win_onehot = NUM_REQ'(1) << win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            ptr        <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            rotate_q   <= 1'b0;
            hold_cnt   <= '0;
`endif
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
            rotate_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q    <= win_onehot;
                        grant_id_q <= win;
                        busy_q     <= 1'b1;
                        state      <= OWN;
`ifdef ARB_HOLD_LIMIT_EN
                        hold_cnt   <= CNT_W'(1);
`endif
                    end
                end
                OWN: begin
                    if (!owner_req) begin
                        // Release: hand over on the same edge if anyone else is waiting.
                        ptr <= owner_next;
                        if (found) begin
                            grant_q    <= win_onehot;
                            grant_id_q <= win;
`ifdef ARB_HOLD_LIMIT_EN
                            hold_cnt   <= CNT_W'(1);
`endif
                        end else begin
                            grant_q    <= '0;
                            grant_id_q <= '0;
                            busy_q     <= 1'b0;
                            state      <= IDLE;
                        end
                    end
`ifdef ARB_HOLD_LIMIT_EN
                    else if (hold_expired && others_pending) begin
                        // Scan from owner+1 cannot return the owner while others wait.
                        grant_q    <= win_onehot;
                        grant_id_q <= win;
                        rotate_q   <= 1'b1;
                        hold_cnt   <= CNT_W'(1);
                    end else if (!hold_expired) begin
                        // Saturates at MAX_HOLD while the owner is alone.
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign arb.grant    = grant_q;
    assign arb.grant_id = grant_id_q;
    assign arb.busy     = busy_q;
`ifdef ARB_HOLD_LIMIT_EN
    assign arb.rotate   = rotate_q;
`else
    assign arb.rotate   = 1'b0;
`endif
endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// tb/tb_rr_arbiter_ctrl.sv - self-checking bench for rr_arbiter_ctrl (NUM_REQ=4, MAX_HOLD=4)
module tb_rr_arbiter_ctrl;
    localparam int N  = 4;
    localparam int MH = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;

    rr_arbiter_ctrl_if #(.NUM_REQ(N)) bus ();

    rr_arbiter_ctrl #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .arb     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = idle), pointer, cycles owned so far.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_req   = 0;
    bit m_rot   = 1'b0;

    function automatic int pick(input int r, input int start);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (start + k) % N;
            if (((r >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_owner = -1;
                m_ptr   = 0;
                m_held  = 0;
                m_rot   = 1'b0;
            end else begin
                m_req = int'(bus.request);
                m_rot = 1'b0;
                if (m_owner < 0) begin
                    m_owner = pick(m_req, m_ptr);
                    m_held  = (m_owner >= 0) ? 1 : 0;
                end else if (((m_req >> m_owner) & 1) == 0) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = pick(m_req, m_ptr);
                    m_held  = 1;
                end else if (HOLD_EN && m_held >= MH && (m_req & ~(1 << m_owner)) != 0) begin
                    m_owner = pick(m_req, (m_owner + 1) % N);
                    m_rot   = 1'b1;
                    m_held  = 1;
                end else begin
                    m_held = m_held + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_model(input string name);
        int eg;
        eg = (m_owner < 0) ? 0 : (1 << m_owner);
        chk({name, " grant"}, int'(bus.grant), eg);
        chk({name, " busy"}, int'(bus.busy), (m_owner >= 0) ? 1 : 0);
        chk({name, " rotate"}, int'(bus.rotate), int'(m_rot));
        if (m_owner >= 0) chk({name, " id"}, int'(bus.grant_id), m_owner);
        chk({name, " onehot"}, ($countones(bus.grant) <= 1) ? 1 : 0, 1);
    endtask

    task automatic step(input logic [3:0] r);
        bus.request = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        bus.request = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset grant", int'(bus.grant), 0);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset id", int'(bus.grant_id), 0);
        chk("reset rotate", int'(bus.rotate), 0);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       rot;
    } vec_t;

    vec_t tbl[17];

    initial begin
        logic [3:0] r;
        int         ei;
        reset_n     = 1'b0;
        bus.request = '0;

        tbl[0]  = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{4'b0010, 4'b0010, 2'd1, 1'b0};
        tbl[3]  = '{4'b1001, 4'b1000, 2'd3, 1'b0};
        tbl[4]  = '{4'b1001, 4'b1000, 2'd3, 1'b0};
        tbl[5]  = '{4'b0001, 4'b0001, 2'd0, 1'b0};
        tbl[6]  = '{4'b0110, 4'b0010, 2'd1, 1'b0};
        tbl[7]  = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[9]  = '{4'b0101, 4'b0001, 2'd0, 1'b0};
        tbl[10] = '{4'b0100, 4'b0100, 2'd2, 1'b0};
        tbl[11] = '{4'b1100, 4'b0100, 2'd2, 1'b0};
        tbl[12] = '{4'b1100, 4'b0100, 2'd2, 1'b0};
        tbl[13] = '{4'b1100, 4'b0100, 2'd2, 1'b0};
        tbl[14] = '{4'b1100, HOLD_EN ? 4'b1000 : 4'b0100, HOLD_EN ? 2'd3 : 2'd2, HOLD_EN};
        tbl[15] = '{4'b1100, HOLD_EN ? 4'b1000 : 4'b0100, HOLD_EN ? 2'd3 : 2'd2, 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

        // Table vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].req);
            chk($sformatf("tbl[%0d] grant", i), int'(bus.grant), int'(tbl[i].grant));
            chk($sformatf("tbl[%0d] busy", i), int'(bus.busy), int'(|tbl[i].grant));
            chk($sformatf("tbl[%0d] rotate", i), int'(bus.rotate), int'(tbl[i].rot));
            if (tbl[i].grant != 4'b0000)
                chk($sformatf("tbl[%0d] id", i), int'(bus.grant_id), int'(tbl[i].id));
        end

        // Asynchronous reset in the middle of a cycle clears outputs before the next edge
        do_reset();
        step(4'b0100);
        chk("t1 pre grant", int'(bus.grant), 4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1 async grant", int'(bus.grant), 0);
        chk("t1 async busy", int'(bus.busy), 0);
        chk("t1 async id", int'(bus.grant_id), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b0010);
        chk("t1 post grant", int'(bus.grant), 2);
        chk("t1 post id", int'(bus.grant_id), 1);

        // All four requesting: rotation every MAX_HOLD cycles when the limit is enabled
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step(4'b1111);
            ei = HOLD_EN ? ((k - 1) / MH) % N : 0;
            chk($sformatf("t3 grant k=%0d", k), int'(bus.grant), 1 << ei);
            chk($sformatf("t3 rotate k=%0d", k), int'(bus.rotate),
                (HOLD_EN && k > 1 && ((k - 1) % MH) == 0) ? 1 : 0);
            chk_model($sformatf("t3 model k=%0d", k));
        end

        // Lone owner holds past MAX_HOLD; a newcomer forces rotation immediately
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step(4'b0100);
            chk($sformatf("t5 grant k=%0d", k), int'(bus.grant), 4);
            chk($sformatf("t5 rotate k=%0d", k), int'(bus.rotate), 0);
        end
        step(4'b0101);
        chk("t5 newcomer grant", int'(bus.grant), HOLD_EN ? 1 : 4);
        chk("t5 newcomer rotate", int'(bus.rotate), HOLD_EN ? 1 : 0);
        chk_model("t5 newcomer model");

        // Two requesters held: no rotation without the limit; release hands over
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step(4'b0011);
            chk_model($sformatf("t6 model k=%0d", k));
            chk($sformatf("t6 grant k=%0d", k), int'(bus.grant),
                HOLD_EN ? ((m_owner < 0) ? 0 : (1 << m_owner)) : 1);
        end
        step(4'b0010);
        chk("t6 release grant", int'(bus.grant), 2);
        chk("t6 release rotate", int'(bus.rotate), 0);

        // Randomized request patterns against the reference model
        do_reset();
        r = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(3, 0) == 0) r = r ^ 4'(1 << b);
            end
            step(r);
            chk_model($sformatf("rand c=%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
